// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// The tag space is unified: GPRs R0-R7 occupy tags 0-7, specials follow.
package fwd_scoreboard_pkg;

    localparam int HIST_TAG_W = 4;

    localparam logic [HIST_TAG_W-1:0] TAG_T  = 4'd8;
    localparam logic [HIST_TAG_W-1:0] TAG_SP = 4'd9;
    localparam logic [HIST_TAG_W-1:0] TAG_IH = 4'd10;
    localparam logic [HIST_TAG_W-1:0] TAG_RA = 4'd11;

    // forwardSel value meaning "take the operand from the register file"
    localparam int SEL_REGFILE = 0;

    // One tracked producer; valid means it will write dest.
    typedef struct packed {
        logic                  valid;
        logic [HIST_TAG_W-1:0] dest;
        logic                  isLoad;
    } hist_entry_t;

    localparam hist_entry_t HIST_BUBBLE = '0;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// EX-stage view of the forwarding scoreboard: the producer/consumer fields
// from ID/EX plus pipeline control in, operand selects and stall out.
interface fwd_scoreboard_if #(
    parameter int TAG_W  = 4,
    parameter int NUM_RD = 2,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic                    exValid;
    logic                    exRegWrite;
    logic                    exIsLoad;
    logic [TAG_W-1:0]        exDest;
    logic [NUM_RD*TAG_W-1:0] rdAddr;
    logic [NUM_RD-1:0]       rdUsed;
    logic                    stallIn;
    logic                    flushEx;
    logic [NUM_RD*SEL_W-1:0] forwardSel;
    logic                    loadUseStall;
    logic [CNT_W-1:0]        stallCount;

    // pipeline / hazard-controller side
    modport master (
        output exValid, exRegWrite, exIsLoad, exDest, rdAddr, rdUsed,
               stallIn, flushEx,
        input  forwardSel, loadUseStall, stallCount
    );

    // scoreboard side
    modport slave (
        input  exValid, exRegWrite, exIsLoad, exDest, rdAddr, rdUsed,
               stallIn, flushEx,
        output forwardSel, loadUseStall, stallCount
    );
endinterface

// File: rtl/fwd_scoreboard_port_match.sv
// Priority match of one EX read port against the producer history.
// The youngest matching producer decides; a too-young load blocks the
// port instead of letting an older producer supply stale data.
module fwd_port_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int TAG_W    = HIST_TAG_W,
    parameter int SEL_W    = 2,
    parameter int LOAD_LAT = 1
) (
    input  hist_entry_t      i_hist [DEPTH],
    input  logic [TAG_W-1:0] i_rd_addr,
    input  logic             i_rd_used,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_hazard
);

    logic w_found;

    // Scan from youngest to oldest, stop at the first tag hit.
    always_comb begin
        o_sel    = SEL_W'(SEL_REGFILE);
        o_hazard = 1'b0;
        w_found  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && i_rd_used && i_hist[i].valid &&
                (i_hist[i].dest == i_rd_addr)) begin
                w_found = 1'b1;
                if (i_hist[i].isLoad && (i < LOAD_LAT))
                    o_hazard = 1'b1;
                else
                    o_sel = SEL_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: registered history of the last DEPTH producers
// after EX, per-port forward selects for EX, and load-use stall generation.
// On a load-use stall the EX instruction is held and a bubble enters the
// history, so the load drifts toward a stage where its data is available.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int TAG_W    = HIST_TAG_W,
    parameter int DEPTH    = 2,
    parameter int NUM_RD   = 2,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    fwd_scoreboard_if.slave    bus
);

    hist_entry_t             r_hist [DEPTH];
    logic [CNT_W-1:0]        r_stall_cnt;

    logic [SEL_W-1:0]        w_sel [NUM_RD];
    logic                    w_hazard [NUM_RD];
    logic [NUM_RD*SEL_W-1:0] w_sel_flat;
    logic                    w_load_use;
    hist_entry_t             w_ex_entry;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        fwd_port_match #(
            .DEPTH    (DEPTH),
            .TAG_W    (TAG_W),
            .SEL_W    (SEL_W),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .i_hist    (r_hist),
            .i_rd_addr (bus.rdAddr[p*TAG_W +: TAG_W]),
            .i_rd_used (bus.rdUsed[p]),
            .o_sel     (w_sel[p]),
            .o_hazard  (w_hazard[p])
        );
    end

    // Combine per-port results; a frozen pipeline never requests a stall.
    always_comb begin
        w_load_use = 1'b0;
        w_sel_flat = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_sel_flat[p*SEL_W +: SEL_W] = w_sel[p];
            if (w_hazard[p])
                w_load_use = 1'b1;
        end
        w_load_use = w_load_use & ~bus.stallIn;
    end

    // History entry the current EX instruction would become.
    always_comb begin
        w_ex_entry        = HIST_BUBBLE;
        w_ex_entry.valid  = bus.exValid & bus.exRegWrite;
        w_ex_entry.dest   = bus.exDest;
        w_ex_entry.isLoad = bus.exIsLoad;
    end

    // Advance the history unless frozen; insert a bubble on stall or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_hist[i] <= HIST_BUBBLE;
            r_stall_cnt <= '0;
        end else if (!bus.stallIn) begin
            for (int i = 1; i < DEPTH; i++)
                r_hist[i] <= r_hist[i-1];
            r_hist[0] <= (w_load_use || bus.flushEx) ? HIST_BUBBLE : w_ex_entry;
            if (w_load_use && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.forwardSel   = w_sel_flat;
    assign bus.loadUseStall = w_load_use;
    assign bus.stallCount   = r_stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: a directed vector table on the default
// configuration, hand-written multi-cycle sequences on a deep configuration
// (DEPTH=4, LOAD_LAT=2, 2-bit counter), then random traffic on both against
// a behavioural model of the producer history.
module tb_fwd_scoreboard;
    import fwd_scoreboard_pkg::*;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    fwd_scoreboard_if #(.TAG_W(4), .NUM_RD(2), .SEL_W(2), .CNT_W(16)) ifa ();
    fwd_scoreboard_if #(.TAG_W(4), .NUM_RD(2), .SEL_W(3), .CNT_W(2))  ifb ();

    fwd_scoreboard #(.TAG_W(4), .DEPTH(2), .NUM_RD(2), .LOAD_LAT(1),
                     .SEL_W(2), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));

    fwd_scoreboard #(.TAG_W(4), .DEPTH(4), .NUM_RD(2), .LOAD_LAT(2),
                     .SEL_W(3), .CNT_W(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       ev, rw, ld;
        int       dest;
        int       a0, a1;
        bit [1:0] used;
        bit       si, fl;
        int       e0, e1;
        bit       es;
        int       ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(bit ev, bit rw, bit ld, int dest, int a0, int a1,
                                 bit [1:0] used, bit si, bit fl,
                                 int e0, int e1, bit es, int ec);
        vec_t v;
        v.ev = ev; v.rw = rw; v.ld = ld; v.dest = dest;
        v.a0 = a0; v.a1 = a1; v.used = used; v.si = si; v.fl = fl;
        v.e0 = e0; v.e1 = e1; v.es = es; v.ec = ec;
        return v;
    endfunction

    task automatic set_if_a(input bit ev, rw, ld, input int dest, a0, a1,
                            input bit [1:0] used, input bit si, fl);
        ifa.exValid    = ev;
        ifa.exRegWrite = rw;
        ifa.exIsLoad   = ld;
        ifa.exDest     = 4'(dest);
        ifa.rdAddr     = {4'(a1), 4'(a0)};
        ifa.rdUsed     = used;
        ifa.stallIn    = si;
        ifa.flushEx    = fl;
    endtask

    task automatic set_if_b(input bit ev, rw, ld, input int dest, a0, a1,
                            input bit [1:0] used, input bit si, fl);
        ifb.exValid    = ev;
        ifb.exRegWrite = rw;
        ifb.exIsLoad   = ld;
        ifb.exDest     = 4'(dest);
        ifb.rdAddr     = {4'(a1), 4'(a0)};
        ifb.rdUsed     = used;
        ifb.stallIn    = si;
        ifb.flushEx    = fl;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit v;
        int dest;
        bit ld;
    } mentry_t;
    typedef mentry_t mhist_t [4];

    function automatic void meval(input mhist_t h, input int depth, input int lat,
                                  input int addr, input bit used,
                                  output int sel, output bit haz);
        sel = 0;
        haz = 1'b0;
        for (int i = 0; i < depth; i++) begin
            if (used && h[i].v && h[i].dest == addr) begin
                if (h[i].ld && i < lat) haz = 1'b1;
                else                     sel = i + 1;
                return;
            end
        end
    endfunction

    function automatic void mstep(inout mhist_t h, inout int cnt,
                                  input int depth, input int cmax, input bit stall,
                                  input bit ev, rw, ld, input int dest,
                                  input bit si, fl);
        if (si) return;
        for (int i = depth - 1; i >= 1; i--) h[i] = h[i-1];
        if (stall || fl) h[0] = '{1'b0, 0, 1'b0};
        else             h[0] = '{ev & rw, dest, ld};
        if (stall && cnt < cmax) cnt++;
    endfunction

    mhist_t ma, mb;
    int     ca, cb;

    initial begin
        int sa0, sa1, sb0, sb1;
        bit ha0, ha1, hb0, hb1, sta, stb;
        bit ev, rw, ld, si, fl;
        int dest, a0, a1;
        bit [1:0] used;

        rst = 1'b0;
        set_if_a(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        set_if_b(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

        // Cycle-by-cycle vectors for the 2-deep, LOAD_LAT=1 instance.
        // Fields: ev rw ld dest a0 a1 used si fl | sel0 sel1 stall count
        tbl.push_back(mkv(1,1,0,3,  0,0,2'b00,0,0, 0,0,0,0)); // write R3
        tbl.push_back(mkv(0,0,0,0,  3,0,2'b01,0,0, 1,0,0,0)); // read R3 -> stage0
        tbl.push_back(mkv(0,0,0,0,  3,0,2'b01,0,0, 2,0,0,0)); // -> stage1
        tbl.push_back(mkv(0,0,0,0,  3,0,2'b01,0,0, 0,0,0,0)); // aged out
        tbl.push_back(mkv(1,1,0,9,  0,0,2'b00,0,0, 0,0,0,0)); // write SP
        tbl.push_back(mkv(1,1,0,9,  0,0,2'b00,0,0, 0,0,0,0)); // write SP again
        tbl.push_back(mkv(0,0,0,0,  9,9,2'b10,0,0, 0,1,0,0)); // youngest SP wins
        tbl.push_back(mkv(0,0,0,0,  0,0,2'b00,0,0, 0,0,0,0));
        tbl.push_back(mkv(1,1,1,5,  0,0,2'b00,0,0, 0,0,0,0)); // load R5
        tbl.push_back(mkv(1,0,0,0,  5,0,2'b01,0,0, 0,0,1,0)); // load-use stall
        tbl.push_back(mkv(1,0,0,0,  5,0,2'b01,0,0, 2,0,0,1)); // forward from stage1
        tbl.push_back(mkv(1,1,1,6,  0,0,2'b00,0,0, 0,0,0,1)); // load R6
        tbl.push_back(mkv(1,0,0,0,  0,6,2'b10,1,0, 0,0,0,1)); // frozen hazard
        tbl.push_back(mkv(1,0,0,0,  0,6,2'b10,1,0, 0,0,0,1));
        tbl.push_back(mkv(1,0,0,0,  0,6,2'b10,1,0, 0,0,0,1));
        tbl.push_back(mkv(1,0,0,0,  0,6,2'b10,0,0, 0,0,1,1)); // unfrozen -> stall
        tbl.push_back(mkv(1,0,0,0,  0,6,2'b10,0,0, 0,2,0,2));
        tbl.push_back(mkv(1,1,0,2,  0,0,2'b00,0,1, 0,0,0,2)); // flushed write R2
        tbl.push_back(mkv(0,0,0,0,  2,2,2'b11,0,0, 0,0,0,2));
        tbl.push_back(mkv(0,0,0,0,  2,2,2'b11,0,0, 0,0,0,2));
        tbl.push_back(mkv(1,1,0,0,  0,0,2'b00,0,0, 0,0,0,2)); // write R0
        tbl.push_back(mkv(1,1,0,1,  0,0,2'b11,0,0, 1,1,0,2)); // R0 forwards
        tbl.push_back(mkv(0,0,0,0,  0,1,2'b11,0,0, 2,1,0,2)); // ports differ
        tbl.push_back(mkv(0,0,0,0,  1,1,2'b00,0,0, 0,0,0,2)); // rdUsed=0
        tbl.push_back(mkv(1,1,1,7,  0,0,2'b00,0,0, 0,0,0,2)); // load R7
        tbl.push_back(mkv(1,1,0,3,  7,0,2'b01,0,1, 0,0,1,2)); // stall + flush
        tbl.push_back(mkv(0,0,0,0,  7,3,2'b11,0,0, 2,0,0,3)); // single bubble

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.a_sel",   int'(ifa.forwardSel),   0);
        chk("rst.a_stall", int'(ifa.loadUseStall), 0);
        chk("rst.a_cnt",   int'(ifa.stallCount),   0);
        chk("rst.b_cnt",   int'(ifb.stallCount),   0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            set_if_a(tbl[k].ev, tbl[k].rw, tbl[k].ld, tbl[k].dest, tbl[k].a0,
                     tbl[k].a1, tbl[k].used, tbl[k].si, tbl[k].fl);
            #1;
            chk($sformatf("tbl%0d.sel0", k),  int'(ifa.forwardSel[1:0]), tbl[k].e0);
            chk($sformatf("tbl%0d.sel1", k),  int'(ifa.forwardSel[3:2]), tbl[k].e1);
            chk($sformatf("tbl%0d.stall", k), int'(ifa.loadUseStall),    int'(tbl[k].es));
            chk($sformatf("tbl%0d.cnt", k),   int'(ifa.stallCount),      tbl[k].ec);
        end
        @(negedge clk);
        set_if_a(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

        // Deep instance: two-cycle load-use, then counter saturation at 3.
        @(negedge clk); set_if_b(1,1,1,1, 0,0,2'b00,0,0); #1;
        chk("deep.ld1_stall", int'(ifb.loadUseStall), 0);
        @(negedge clk); set_if_b(1,0,0,0, 1,0,2'b01,0,0); #1;
        chk("deep.use1_stall_c1", int'(ifb.loadUseStall), 1);
        chk("deep.use1_sel_c1",   int'(ifb.forwardSel[2:0]), 0);
        @(negedge clk); #1;
        chk("deep.use1_stall_c2", int'(ifb.loadUseStall), 1);
        chk("deep.use1_cnt_c2",   int'(ifb.stallCount), 1);
        @(negedge clk); #1;
        chk("deep.use1_stall_c3", int'(ifb.loadUseStall), 0);
        chk("deep.use1_sel_c3",   int'(ifb.forwardSel[2:0]), 3);
        chk("deep.use1_cnt_c3",   int'(ifb.stallCount), 2);
        @(negedge clk); set_if_b(1,1,1,4, 0,0,2'b00,0,0); #1;
        @(negedge clk); set_if_b(1,0,0,0, 0,4,2'b10,0,0); #1;
        chk("deep.use4_stall_c1", int'(ifb.loadUseStall), 1);
        @(negedge clk); #1;
        chk("deep.use4_stall_c2", int'(ifb.loadUseStall), 1);
        chk("deep.use4_cnt_c2",   int'(ifb.stallCount), 3);
        @(negedge clk); #1;
        chk("deep.use4_sel1_c3",  int'(ifb.forwardSel[5:3]), 3);
        chk("deep.cnt_saturated", int'(ifb.stallCount), 3);
        @(negedge clk);
        set_if_b(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

        // Asynchronous reset while a load-use stall is active.
        @(negedge clk); set_if_a(1,1,1,5, 0,0,2'b00,0,0);
        @(negedge clk); set_if_a(1,0,0,0, 5,5,2'b11,0,0); #1;
        chk("midrst.stall_before", int'(ifa.loadUseStall), 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst.sel",   int'(ifa.forwardSel),   0);
        chk("midrst.stall", int'(ifa.loadUseStall), 0);
        chk("midrst.cnt_a", int'(ifa.stallCount),   0);
        chk("midrst.cnt_b", int'(ifb.stallCount),   0);
        set_if_a(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Random traffic on both instances against the model.
        for (int i = 0; i < 4; i++) begin
            ma[i] = '{1'b0, 0, 1'b0};
            mb[i] = '{1'b0, 0, 1'b0};
        end
        ca = 0;
        cb = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ev   = ($urandom_range(0, 9) < 8);
            rw   = ($urandom_range(0, 9) < 7);
            ld   = ($urandom_range(0, 9) < 4);
            dest = $urandom_range(0, 3);
            a0   = $urandom_range(0, 3);
            a1   = $urandom_range(0, 3);
            used = 2'($urandom_range(0, 3));
            si   = ($urandom_range(0, 9) == 0);
            fl   = ($urandom_range(0, 9) == 0);
            set_if_a(ev, rw, ld, dest, a0, a1, used, si, fl);
            set_if_b(ev, rw, ld, dest, a0, a1, used, si, fl);
            #1;
            meval(ma, 2, 1, a0, used[0], sa0, ha0);
            meval(ma, 2, 1, a1, used[1], sa1, ha1);
            sta = (ha0 | ha1) & ~si;
            meval(mb, 4, 2, a0, used[0], sb0, hb0);
            meval(mb, 4, 2, a1, used[1], sb1, hb1);
            stb = (hb0 | hb1) & ~si;
            chk($sformatf("rndA%0d.sel0", n),  int'(ifa.forwardSel[1:0]), sa0);
            chk($sformatf("rndA%0d.sel1", n),  int'(ifa.forwardSel[3:2]), sa1);
            chk($sformatf("rndA%0d.stall", n), int'(ifa.loadUseStall),    int'(sta));
            chk($sformatf("rndA%0d.cnt", n),   int'(ifa.stallCount),      ca);
            chk($sformatf("rndB%0d.sel0", n),  int'(ifb.forwardSel[2:0]), sb0);
            chk($sformatf("rndB%0d.sel1", n),  int'(ifb.forwardSel[5:3]), sb1);
            chk($sformatf("rndB%0d.stall", n), int'(ifb.loadUseStall),    int'(stb));
            chk($sformatf("rndB%0d.cnt", n),   int'(ifb.stallCount),      cb);
            mstep(ma, ca, 2, 65535, sta, ev, rw, ld, dest, si, fl);
            mstep(mb, cb, 4, 3,     stb, ev, rw, ld, dest, si, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational forwarding logic. It keeps its own registered history of the last DEPTH producer instructions after EX, in place of fixed EX/MEM and MEM/WB taps.
- Generates a per-read-port forward select for the instruction in EX, for both general-purpose and special registers, using a unified tag space.
- Detects load-use hazards against a configurable load latency, requests a stall and inserts bubbles into its history.
- Sits beside the ID/EX register; drives the EX operand muxes and the hazard/stall controller.

Parameters:
- TAG_W, 4, unified register tag width: 0-7 GPR R0-R7, 8 T, 9 SP, 10 IH, 11 RA, 12-15 reserved.
- DEPTH, 2, number of tracked producer stages after EX (2..4). Stage 0 = EX/MEM.
- NUM_RD, 2, number of EX read ports.
- LOAD_LAT, 1, load data is forwardable only from stage index >= LOAD_LAT (1..DEPTH-1).
- SEL_W, 2, select width; must be >= clog2(DEPTH+1).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- exValid  in  1  EX holds a real instruction
- exRegWrite  in  1  EX instruction writes a register
- exIsLoad  in  1  EX instruction is a memory load
- exDest  in  TAG_W  EX destination tag
- rdAddr  in  NUM_RD*TAG_W  EX source tags, port p at [p*TAG_W +: TAG_W]
- rdUsed  in  NUM_RD  port p actually reads its operand
- stallIn  in  1  external freeze, e.g. memory structural hazard
- flushEx  in  1  squash the EX instruction
- forwardSel  out  NUM_RD*SEL_W  per port: 0 = register file, k = stage k-1 result
- loadUseStall  out  1  hold IF/ID/EX this cycle
- stallCount  out  CNT_W  saturating count of loadUseStall cycles

Behaviour:
- State: DEPTH entries, each holding {valid, dest, isLoad}. valid means the entry will write a register.
- Reset (rst low, asynchronous): all entries have valid=0, dest=0, isLoad=0, and stallCount=0. As a result forwardSel=0 and loadUseStall=0 for as long as rst is low and until the first valid producer enters.
- Update on posedge clk. Priority order:
  - stallIn=1: every entry and stallCount hold. flushEx is ignored; the controller must hold flush until stallIn drops.
  - Otherwise: entry[i] <= entry[i-1] for i >= 1.
  - entry[0] takes {exValid & exRegWrite, exDest, exIsLoad}, except it takes a bubble (valid=0) when loadUseStall=1 or flushEx=1.
  - With loadUseStall=1 the EX instruction stays in place and the older entries still advance. This is the bubble insertion.
- Forwarding is combinational from the registered entries and the current rdAddr, with zero latency.
  - For port p, the match condition is: rdUsed[p], entry[i].valid, and entry[i].dest == rdAddr[p].
  - Youngest wins: the lowest i that matches gives forwardSel = i+1.
  - If the winning entry is a load with i < LOAD_LAT, forwardSel = 0 and the port raises a load-use hazard. An older match is never used in its place.
  - No match gives forwardSel = 0.
- Tag 0 (R0) is a normal register and forwards like any other tag.
- Special registers share the same compare path as GPRs, with no separate type field.
- loadUseStall = OR of all per-port hazards, gated by !stallIn.
  - Because the hazard entry advances one stage per unstalled cycle, the stall lasts exactly LOAD_LAT - i cycles.
  - The port then selects the load at stage LOAD_LAT.
- stallCount increments on each cycle with loadUseStall=1 and saturates at all-ones.
- Simultaneous events:
  - Both ports matching different stages select independently.
  - flushEx together with loadUseStall yields a single bubble.
  - Reset mid-stall clears the stall on the same cycle, asynchronously.

Decomposition:
- Shared package holds:
  - the tag constants TAG_T, TAG_SP, TAG_IH, TAG_RA;
  - the SEL_REGFILE constant (0);
  - the history-entry struct {valid, dest, isLoad}.
- One sub-module, fwd_port_match: a combinational priority match for one read port over DEPTH entries, outputting sel and hazard. It is instantiated NUM_RD times by a generate loop.

Test Plan:
1. Defaults. Cycle 0: EX writes R3 (non-load). Cycle 1: EX reads R3 on port 0 -> forwardSel[0]=1. Cycle 2: the same read -> forwardSel[0]=2. Cycle 3 -> 0.
2. Youngest wins. Two back-to-back writes to SP (tag 9), then a read of SP on port 1 -> forwardSel[1]=1, not 2.
3. Load-use, LOAD_LAT=1. Load to R5, then a consumer reads R5 -> loadUseStall=1 for exactly 1 cycle. entry[0] becomes a bubble. The next cycle gives forwardSel=2 and stallCount=1.
4. Deep config, DEPTH=4 and LOAD_LAT=2. Load to R1, then a consumer -> 2 stall cycles, then forwardSel=3 and stallCount=2.
5. Freeze and flush. stallIn=1 held for 3 cycles during an active hazard -> entries unchanged, loadUseStall=0, stallCount unchanged. flushEx on a write to R2 -> a later read of R2 gives forwardSel=0.
6. Reset mid-hazard. Drop rst asynchronously between edges -> forwardSel=0, loadUseStall=0 and stallCount=0 immediately. rdUsed=0 with a matching tag -> forwardSel=0.
